// File: rtl/bf16_addsub_arbiter_if.sv
// Request/response bundle between compute clients and the bf16 add/sub arbiter.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The valid side holds its payload stable
// until that edge. The ready side may raise ready combinationally from valid.
// req_ready is one-hot or zero.
interface bf16_addsub_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [15:0]           rsp_result;
    logic [ID_W-1:0]       rsp_id;

    // Client side: issues requests, consumes responses
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id
    );
endinterface

// File: rtl/bf16_addsub_arbiter.sv
// Round-robin arbiter that shares one combinational bf16 add/sub unit among
// NUM_REQ requesters. One operation is in flight at a time: grant, hold the
// operands for UNIT_LAT cycles, capture the unit's result, then return it
// tagged with the requester index.
module bf16_addsub_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int UNIT_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bf16_addsub_arbiter_if.slave     bus,
    output logic [15:0]              au_a,
    output logic [15:0]              au_b,
    output logic                     au_op,
    input  logic [15:0]              au_result,
    output logic                     busy,
    output logic [1:0]               state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] tag;
    logic [3:0]      cnt;
    logic            rsp_valid_q;
    logic [15:0]     rsp_result_q;
    logic [ID_W-1:0] rsp_id_q;

    logic            any_valid;
    logic            hi_found;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;
    logic [ID_W-1:0] grant_idx;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic            sel_op;

    // Round-robin pick: lowest valid index above last_grant, else lowest valid overall
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                lo_idx = ID_W'(i);
                if (i > int'(last_grant)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        any_valid = |bus.req_valid;
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Operand mux for the requester currently being granted
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(grant_idx) == i) begin
                sel_a  = bus.req_a[16*i +: 16];
                sel_b  = bus.req_b[16*i +: 16];
                sel_op = bus.req_op[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and grant; ready is held low while in reset
    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    state_next = ST_BUSY;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        bus.req_ready[i] = rst_n && (int'(grant_idx) == i);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on grant, count the settle window, capture result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            au_a         <= '0;
            au_b         <= '0;
            au_op        <= 1'b0;
            tag          <= '0;
            last_grant   <= ID_W'(NUM_REQ - 1);
            cnt          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        au_a       <= sel_a;
                        au_b       <= sel_b;
                        au_op      <= sel_op;
                        tag        <= grant_idx;
                        last_grant <= grant_idx;
                        cnt        <= 4'(UNIT_LAT - 1);
                    end
                end
                ST_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result_q <= au_result;
                        rsp_id_q     <= tag;
                        rsp_valid_q  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_id     = rsp_id_q;
    assign busy           = (state != ST_IDLE);
    assign state_dbg      = state;

endmodule
